// File: rtl/fir4_share_pkg.sv
// Shared types and constants for the time-multiplexed 4-tap moving-sum scheduler.
package fir4_share_pkg;

  localparam int W_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    ADD1,
    ADD2,
    ADD3,
    OUT
  } sched_state_t;

  // Channel-index width; never below 1 so a single-bit index always exists.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fir4_share_adder.sv
// The single shared accumulate adder; kept apart so its architecture can change freely.
module fir4_share_adder #(
  parameter int WS = 18
) (
  input  logic [WS-1:0] a_i,
  input  logic [WS-1:0] b_i,
  output logic [WS-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/fir4_share_sched.sv
// Round-robin scheduler sharing one adder among NCH 4-tap moving-sum channels.
module fir4_share_sched
  import fir4_share_pkg::*;
#(
  parameter int W   = W_DEFAULT,
  parameter int NCH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCH-1:0]          in_valid,
  input  logic [NCH*W-1:0]        in_data,
  output logic [NCH-1:0]          in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [W+1:0]            out_data,
  output logic [ch_w(NCH)-1:0]    out_ch,
  output logic                    busy
);

  localparam int CW = ch_w(NCH);

  sched_state_t    state_q;
  logic [CW-1:0]   ptr_q;
  logic [CW-1:0]   cur_q;
  logic [W+1:0]    acc_q;
  logic [W+1:0]    acc_d;
  logic [W-1:0]    hist_q [NCH][4];

  logic [W-1:0]    samp [NCH];
  logic            gnt_vld;
  logic [CW-1:0]   gnt_idx;
  logic [CW-1:0]   scan_idx;
  logic [W+1:0]    op_a;
  logic [W+1:0]    op_b;

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      samp[c] = in_data[c*W +: W];
    end
  end

  // Scan starts at ptr_q; NCH is a power of two so the index wraps naturally.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < NCH; k++) begin
      scan_idx = ptr_q + CW'(k);
      if (!gnt_vld && in_valid[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  assign in_ready = (state_q == IDLE && gnt_vld)
                    ? ({{(NCH-1){1'b0}}, 1'b1} << gnt_idx) : '0;

  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state_q)
      ADD1: begin
        op_a = {2'b00, hist_q[cur_q][0]};
        op_b = {2'b00, hist_q[cur_q][1]};
      end
      ADD2: begin
        op_a = acc_q;
        op_b = {2'b00, hist_q[cur_q][2]};
      end
      ADD3: begin
        op_a = acc_q;
        op_b = {2'b00, hist_q[cur_q][3]};
      end
      default: ;
    endcase
  end

  fir4_share_adder #(.WS(W+2)) u_adder (
    .a_i   (op_a),
    .b_i   (op_b),
    .sum_o (acc_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cur_q   <= '0;
      acc_q   <= '0;
      for (int c = 0; c < NCH; c++) begin
        for (int t = 0; t < 4; t++) begin
          hist_q[c][t] <= '0;
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            hist_q[gnt_idx][0] <= samp[gnt_idx];
            hist_q[gnt_idx][1] <= hist_q[gnt_idx][0];
            hist_q[gnt_idx][2] <= hist_q[gnt_idx][1];
            hist_q[gnt_idx][3] <= hist_q[gnt_idx][2];
            cur_q              <= gnt_idx;
            ptr_q              <= gnt_idx + CW'(1);
            state_q            <= ADD1;
          end
        end
        ADD1: begin
          acc_q   <= acc_d;
          state_q <= ADD2;
        end
        ADD2: begin
          acc_q   <= acc_d;
          state_q <= ADD3;
        end
        ADD3: begin
          acc_q   <= acc_d;
          state_q <= OUT;
        end
        OUT: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = (state_q == OUT);
  assign out_data  = acc_q;
  assign out_ch    = cur_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fir4_share_sched.sv
// Scoreboard bench for fir4_share_sched: directed vectors, decoupled output monitor.
module tb_fir4_share_sched;

  localparam int W   = 16;
  localparam int NCH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NCH-1:0]   in_valid = '0;
  logic [NCH*W-1:0] in_data = '0;
  logic [NCH-1:0]   in_ready;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [W+1:0]     out_data;
  logic [1:0]       out_ch;
  logic             busy;

  typedef struct {
    int           ch;
    logic [W+1:0] data;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  fir4_share_sched #(.W(W), .NCH(NCH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .busy      (busy)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int ch, input logic [W+1:0] d);
    exp_t e;
    e.ch   = ch;
    e.data = d;
    e.cyc  = cyc;
    q.push_back(e);
  endtask

  // Returns #1 after the accept edge.
  task automatic send(input int ch, input logic [W-1:0] d, input logic [W+1:0] exp, input bit push);
    bit got;
    got = 1'b0;
    @(negedge clk);
    in_valid[ch] = 1'b1;
    in_data[ch*W +: W] = d;
    for (int i = 0; i < 100 && !got; i++) begin
      #1;
      if (in_ready[ch]) begin
        @(posedge clk);
        #1;
        got = 1'b1;
        if (push) push_exp(ch, exp);
      end else begin
        @(negedge clk);
      end
    end
    in_valid[ch] = 1'b0;
    chk("send_accepted", 32'(got), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      #3;
      if (q.size() == 0 && !busy) done = 1'b1;
    end
    chk("drain_done", 32'(done), 1);
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    bit   prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        prev = 1'b0;
      end else begin
        chk("in_ready_onehot0", 32'($onehot0(in_ready)), 1);
        if (out_valid && !prev) begin
          if (q.size() == 0) chk("unexpected_out_valid", 32'(out_valid), 0);
          else chk("latency", 32'(cyc - q[0].cyc), 3);
        end
        if (out_valid && out_ready && q.size() != 0) begin
          e = q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.data));
          chk("out_ch", 32'(out_ch), 32'(e.ch));
        end
        prev = out_valid;
      end
    end
  end

  initial begin
    int           order [6];
    int           sums  [6];
    int           k;
    bit           got;
    logic [W+1:0] d4 [4];

    order = '{0, 1, 2, 3, 0, 1};
    sums  = '{1, 2, 3, 4, 2, 4};
    d4    = '{18'h0FFFF, 18'h1FFFE, 18'h2FFFD, 18'h3FFFC};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_ch", 32'(out_ch), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    reset = 1'b0;

    // Single channel running sum
    send(0, 1, 1, 1);
    send(0, 2, 3, 1);
    send(0, 3, 6, 1);
    send(0, 4, 10, 1);
    send(0, 5, 14, 1);
    drain();

    // Round-robin with every channel requesting
    do_reset();
    @(negedge clk);
    for (int c = 0; c < NCH; c++) in_data[c*W +: W] = W'(c + 1);
    in_valid = '1;
    k = 0;
    for (int i = 0; i < 200 && k < 6; i++) begin
      #1;
      if (|in_ready) begin
        chk("rr_grant", 32'(in_ready), 32'(1 << order[k]));
        @(posedge clk);
        #1;
        push_exp(order[k], 18'(sums[k]));
        k++;
        if (k == 6) in_valid = '0;
      end
      @(negedge clk);
    end
    in_valid = '0;
    chk("rr_grants_seen", 32'(k), 6);
    drain();

    // Back-pressure: ch0 history {1,1,0,0} -> 9+1+1 = 11
    @(negedge clk);
    out_ready = 1'b0;
    send(0, 9, 11, 1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    chk("bp_out_valid_reached", 32'(got), 1);
    in_valid[1] = 1'b1;
    in_data[1*W +: W] = 16'd77;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #3;
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_out_data", 32'(out_data), 11);
      chk("bp_out_ch", 32'(out_ch), 0);
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    chk("bp_back_to_idle", 32'(busy), 0);
    // ch1 history still {2,2,0,0}: 10+2+2 = 14
    send(1, 10, 14, 1);
    drain();

    // Maximum width
    do_reset();
    for (int i = 0; i < 4; i++) send(2, 16'hFFFF, d4[i], 1);
    drain();

    // Reset during ADD2 of ch3 discards the sample
    send(3, 5, 0, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_out_valid", 32'(out_valid), 0);
    chk("abort_out_data", 32'(out_data), 0);
    chk("abort_out_ch", 32'(out_ch), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    in_valid = 4'b1010;
    #1;
    chk("abort_ptr_zero", 32'(in_ready), 32'b0010);
    in_valid = '0;
    send(3, 7, 7, 1);
    drain();

    // Channel isolation
    do_reset();
    send(0, 10, 10, 1);
    send(1, 100, 100, 1);
    send(0, 20, 30, 1);
    send(1, 200, 300, 1);
    drain();

    chk("scoreboard_empty", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
